// File: rtl/adma_block_engine_if.sv
// Bus interface of the ADMA block engine.
// Carries the register-file controls (start, abort, direction, gap control, address/size/count),
// the RAM port (address, read/write strobes, data in/out), the FIFO port (push/pop, full/empty,
// data in/out) and the status outputs (busy, block_gap_event, transfer_complete, error_status).
// master: the engine side. slave: the register file / RAM / FIFO side.
interface adma_block_engine_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned BSIZE_W = 12,
    parameter int unsigned BCNT_W  = 16
);
    // Control from the register file
    logic               start;
    logic               abort;
    logic               direction;
    logic               stop_at_gap;
    logic               continue_req;
    logic [ADDR_W-1:0]  start_address;
    logic [BSIZE_W-1:0] block_size;
    logic [BCNT_W-1:0]  block_count;
    // RAM / FIFO inputs
    logic [DATA_W-1:0]  data_from_ram;
    logic [DATA_W-1:0]  data_from_fifo;
    logic               fifo_full;
    logic               fifo_empty;
    // RAM / FIFO outputs
    logic [DATA_W-1:0]  data_to_ram;
    logic [DATA_W-1:0]  data_to_fifo;
    logic [ADDR_W-1:0]  ram_address;
    logic               ram_write;
    logic               ram_read;
    logic               fifo_write;
    logic               fifo_read;
    // Status
    logic               busy;
    logic               block_gap_event;
    logic               transfer_complete;
    logic [2:0]         error_status;

    modport master (
        input  start, abort, direction, stop_at_gap, continue_req,
        input  start_address, block_size, block_count,
        input  data_from_ram, data_from_fifo, fifo_full, fifo_empty,
        output data_to_ram, data_to_fifo, ram_address,
        output ram_write, ram_read, fifo_write, fifo_read,
        output busy, block_gap_event, transfer_complete, error_status
    );

    modport slave (
        output start, abort, direction, stop_at_gap, continue_req,
        output start_address, block_size, block_count,
        output data_from_ram, data_from_fifo, fifo_full, fifo_empty,
        input  data_to_ram, data_to_fifo, ram_address,
        input  ram_write, ram_read, fifo_write, fifo_read,
        input  busy, block_gap_event, transfer_complete, error_status
    );
endinterface

// File: rtl/adma_block_engine.sv
// ADMA block engine: moves block_count blocks of block_size bytes between system RAM and the
// host data FIFO, one word at a time, in either direction.
// Ports:
//   CLK    - clock, all logic on the rising edge
//   RESET  - synchronous active-low reset
//   bus_io - adma_block_engine_if master: register-file controls, RAM port, FIFO port, status
// Each word takes a request/pop cycle, a push/store cycle and an ADVANCE cycle (3 cycles
// unstalled). Configuration is validated at start; a bad configuration only loads error_status.
module adma_block_engine #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned BSIZE_W = 12,
    parameter int unsigned BCNT_W  = 16
) (
    input logic                  CLK,
    input logic                  RESET,
    adma_block_engine_if.master  bus_io
);
    localparam int unsigned BPW   = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BPW);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdPush,
        StWrPop,
        StWrStore,
        StAdvance,
        StGap,
        StDone
    } state_e;

    state_e             state_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [BSIZE_W-1:0] wpb_q;
    logic [BSIZE_W-1:0] word_cnt_q;
    logic [BCNT_W-1:0]  bcnt_q;
    logic [BCNT_W-1:0]  blk_cnt_q;
    logic               dir_q;
    logic               busy_q;
    logic               gap_evt_q;
    logic               done_q;
    logic [2:0]         err_q;

    logic [2:0] cfg_err;
    logic       word_last;
    logic       blk_last;
    logic       run;
    state_e     xfer_st;

    always_comb begin
        cfg_err[0] = (bus_io.block_size == '0) ||
                     ((bus_io.block_size % BSIZE_W'(BPW)) != '0);
        cfg_err[1] = (bus_io.block_count == '0);
        cfg_err[2] = ((bus_io.start_address % ADDR_W'(BPW)) != '0);
        word_last  = ((word_cnt_q + BSIZE_W'(1)) == wpb_q);
        blk_last   = word_last && ((blk_cnt_q + BCNT_W'(1)) == bcnt_q);
        xfer_st    = dir_q ? StRdReq : StWrPop;
        // Strobes are suppressed in a cycle that is being aborted or reset.
        run        = RESET && !bus_io.abort;
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wpb_q      <= '0;
            word_cnt_q <= '0;
            bcnt_q     <= '0;
            blk_cnt_q  <= '0;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            gap_evt_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            gap_evt_q <= 1'b0;
            done_q    <= 1'b0;
            if (bus_io.abort) begin
                // In IDLE this also swallows a coincident start.
                state_q <= StIdle;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (bus_io.start) begin
                            err_q <= cfg_err;
                            if (cfg_err == '0) begin
                                addr_q     <= bus_io.start_address;
                                wpb_q      <= bus_io.block_size >> OFF_W;
                                bcnt_q     <= bus_io.block_count;
                                dir_q      <= bus_io.direction;
                                word_cnt_q <= '0;
                                blk_cnt_q  <= '0;
                                busy_q     <= 1'b1;
                                state_q    <= bus_io.direction ? StRdReq : StWrPop;
                            end
                        end
                    end
                    StRdReq: begin
                        if (!bus_io.fifo_full) state_q <= StRdPush;
                    end
                    StRdPush: state_q <= StAdvance;
                    StWrPop: begin
                        if (!bus_io.fifo_empty) state_q <= StWrStore;
                    end
                    StWrStore: state_q <= StAdvance;
                    StAdvance: begin
                        addr_q <= addr_q + ADDR_W'(BPW);
                        if (word_last) begin
                            word_cnt_q <= '0;
                            blk_cnt_q  <= blk_cnt_q + BCNT_W'(1);
                        end else begin
                            word_cnt_q <= word_cnt_q + BSIZE_W'(1);
                        end
                        // Final block wins over a gap request at the same boundary.
                        if (blk_last) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else if (word_last && bus_io.stop_at_gap) begin
                            state_q   <= StGap;
                            gap_evt_q <= 1'b1;
                        end else begin
                            state_q <= xfer_st;
                        end
                    end
                    StGap: begin
                        if (bus_io.continue_req) state_q <= xfer_st;
                    end
                    StDone: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus_io.ram_read          = run && (state_q == StRdReq) && !bus_io.fifo_full;
    assign bus_io.fifo_write        = run && (state_q == StRdPush);
    assign bus_io.fifo_read         = run && (state_q == StWrPop) && !bus_io.fifo_empty;
    assign bus_io.ram_write         = run && (state_q == StWrStore);
    // Read data arrives the cycle after the request, so it is forwarded straight through.
    assign bus_io.data_to_fifo      = (state_q == StRdPush) ? bus_io.data_from_ram : '0;
    assign bus_io.data_to_ram       = (state_q == StWrStore) ? bus_io.data_from_fifo : '0;
    assign bus_io.ram_address       = addr_q;
    assign bus_io.busy              = busy_q;
    assign bus_io.block_gap_event   = gap_evt_q;
    assign bus_io.transfer_complete = done_q && run;
    assign bus_io.error_status      = err_q;
endmodule
